music_sequencer: RTL and testbench
==================================

MUSIC_SEQUENCER -- requirements
Module: music_sequencer

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 Parameter BEAT_HZ, default 8, duration-unit rate; BEAT_CYC = CLK_HZ/BEAT_HZ (integer truncation).
REQ-003 Parameter GAP_CYC, default CLK_HZ/100, silent cycles inserted after every note.
REQ-004 Parameter ADDR_W, default 8, song ROM address width (minimum 3); four songs of SONG_LEN = 2^(ADDR_W-2) words each.
REQ-005 Port clk  input  1  single clock, all state on rising edge.
REQ-006 Port rst  input  1  asynchronous, active-low reset.
REQ-007 Port start  input  1  one-cycle pulse, begins or restarts playback of song_sel.
REQ-008 Port song_sel  input  2  song index, sampled only on the cycle start is accepted.
REQ-009 Port pause  input  1  level; while high, playback is frozen.
REQ-010 Port loop  input  1  level; sampled at end marker, replay when high.
REQ-011 Port rom_addr  output  ADDR_W  registered address to external synchronous ROM.
REQ-012 Port rom_data  input  8  ROM word, valid exactly one cycle after rom_addr changes; [7:3] note code, [2:0] duration.
REQ-013 Port led  output  24  note/status display.
REQ-014 Port buzzer  output  1  registered square-wave tone output.

Function
REQ-015 Note code 0 = rest; 1..21 = C,D,E,F,G,A,B of octaves 4,5,6 at 262,294,330,349,392,440,494, 523,587,659,698,784,880,988, 1047,1175,1319,1397,1568,1760,1976 Hz; 22..30 = rest; 31 = end marker.
REQ-016 Half-period HP(code) = CLK_HZ/(2*freq), truncated, from a constant table; counter width sized for the largest HP.
REQ-017 FSM states: IDLE, FETCH, LATCH, PLAY, GAP, DONE; sole encoding owner is this block.
REQ-018 IDLE/DONE: accepted start -> base = song_sel * SONG_LEN, rom_addr = base, next state FETCH.
REQ-019 FETCH: wait one cycle for rom_data; next LATCH.
REQ-020 LATCH: register note/duration; code 31 with loop=1 -> rom_addr = base, FETCH; code 31 with loop=0 -> DONE; else PLAY with duration counter = (dur+1)*BEAT_CYC.
REQ-021 PLAY: tone counter toggles buzzer every HP cycles, first toggle HP cycles after entry, buzzer starting low; rest codes hold buzzer low; after (dur+1)*BEAT_CYC cycles -> GAP, buzzer forced low.
REQ-022 GAP: buzzer low for GAP_CYC cycles, rom_addr advances by one; next FETCH.
REQ-023 Address wrap: within a song, address base+SONG_LEN-1 advances to base (no end marker required); never crosses into another song.
REQ-024 Pause: high during PLAY or GAP freezes duration, gap and tone counters and forces buzzer low; on release, tone restarts from low with a fresh HP count, duration resumes from frozen value; pause is ignored in IDLE/DONE/FETCH/LATCH.
REQ-025 start in any state (pause included) aborts the current song and restarts per REQ-018 next cycle; start and pause both high -> start accepted, then pause applies from PLAY.
REQ-026 led[20:0]: in PLAY with code 1..21, led[code-1]=1, all others 0; zero otherwise.
REQ-027 led[21]=1 in DONE; led[22]=1 in FETCH/LATCH/PLAY/GAP; led[23]=1 while pause applies per REQ-024.
REQ-028 All outputs registered; no combinational path from inputs to outputs.

Reset
REQ-029 rst low, at any time including mid-note: state IDLE, rom_addr=0, buzzer=0, led=0, all counters 0, immediately and asynchronously.
REQ-030 After rst deasserts, block stays IDLE until a start pulse; rst release is treated as synchronous by the first rising edge.

Verification (CLK_HZ=1_000_000, BEAT_HZ=100, GAP_CYC=50, ADDR_W=8)
REQ-031 Song 1 word 64 = {code 6, dur 1}, word 65 = {31,0}, loop=0; start, song_sel=1 -> rom_addr=64, buzzer toggles every 1136 cycles for 20000 cycles, led[5]=1, then 50 silent cycles, DONE with led=0x200000.
REQ-032 Same song, loop=1 -> after end marker rom_addr returns to 64, note replays; led[21] never set.
REQ-033 Pause asserted 5000 cycles into a 20000-cycle note for 3000 cycles -> buzzer low, led[23]=1, total note time 23000 cycles.
REQ-034 Song 0 with no end marker -> rom_addr runs 0..63 then wraps to 0.
REQ-035 start with song_sel=2 mid-note of song 0 -> next rom_addr=128, buzzer low, led[22] stays 1.
REQ-036 rst low during PLAY -> buzzer, led, rom_addr zero before next clock edge; no output activity until start.

Source files
------------

// File: rtl/music_sequencer.sv
// Song sequencer: walks a four-song ROM, plays each note as a square wave on
// the buzzer for (dur+1) beats, inserts a silent gap, and loops or stops at
// the end marker.
//
//   state   | meaning
//   --------+---------------------------------------------
//   S_IDLE  | waiting for the first start after reset
//   S_FETCH | rom_addr presented, ROM word in flight
//   S_LATCH | ROM word valid, decode note / end marker
//   S_PLAY  | tone running for the note duration
//   S_GAP   | silent inter-note gap, then next address
//   S_DONE  | end marker reached with loop low
module music_sequencer #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int BEAT_HZ = 8,
  parameter int GAP_CYC = CLK_HZ / 100,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        song_sel,
  input  logic              pause,
  input  logic              loop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [23:0]       led,
  output logic              buzzer
);

  localparam int BEAT_CYC = CLK_HZ / BEAT_HZ;
  localparam int OFF_W    = ADDR_W - 2;
  // Lowest note (C4, 262 Hz) has the longest half period.
  localparam int HP_W     = $clog2(CLK_HZ / 524 + 1);
  localparam int DUR_W    = $clog2(8 * BEAT_CYC + 1);
  localparam int GAP_W    = $clog2(GAP_CYC + 2);
  localparam logic [4:0] END_CODE = 5'd31;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_PLAY, S_GAP, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [1:0]        song, song_nxt;
  logic [4:0]        note, note_nxt;
  logic [DUR_W-1:0]  dur_cnt, dur_cnt_nxt;
  logic [HP_W-1:0]   tone_cnt, tone_cnt_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [23:0]       led_nxt;
  logic              buzzer_nxt;
  logic              frozen;
  logic [4:0]        code_in;
  logic [2:0]        dur_in;

  assign code_in = rom_data[7:3];
  assign dur_in  = rom_data[2:0];

  // Half period in clock cycles for each note code; rests return zero.
  function automatic logic [HP_W-1:0] hp_of(input logic [4:0] code);
    case (code)
      5'd1:  hp_of = HP_W'(CLK_HZ / 524);
      5'd2:  hp_of = HP_W'(CLK_HZ / 588);
      5'd3:  hp_of = HP_W'(CLK_HZ / 660);
      5'd4:  hp_of = HP_W'(CLK_HZ / 698);
      5'd5:  hp_of = HP_W'(CLK_HZ / 784);
      5'd6:  hp_of = HP_W'(CLK_HZ / 880);
      5'd7:  hp_of = HP_W'(CLK_HZ / 988);
      5'd8:  hp_of = HP_W'(CLK_HZ / 1046);
      5'd9:  hp_of = HP_W'(CLK_HZ / 1174);
      5'd10: hp_of = HP_W'(CLK_HZ / 1318);
      5'd11: hp_of = HP_W'(CLK_HZ / 1396);
      5'd12: hp_of = HP_W'(CLK_HZ / 1568);
      5'd13: hp_of = HP_W'(CLK_HZ / 1760);
      5'd14: hp_of = HP_W'(CLK_HZ / 1976);
      5'd15: hp_of = HP_W'(CLK_HZ / 2094);
      5'd16: hp_of = HP_W'(CLK_HZ / 2350);
      5'd17: hp_of = HP_W'(CLK_HZ / 2638);
      5'd18: hp_of = HP_W'(CLK_HZ / 2794);
      5'd19: hp_of = HP_W'(CLK_HZ / 3136);
      5'd20: hp_of = HP_W'(CLK_HZ / 3520);
      5'd21: hp_of = HP_W'(CLK_HZ / 3952);
      default: hp_of = '0;
    endcase
  endfunction

  function automatic logic is_tone(input logic [4:0] code);
    return (code >= 5'd1) && (code <= 5'd21);
  endfunction

  // State, counters and all outputs are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      song     <= '0;
      note     <= '0;
      dur_cnt  <= '0;
      tone_cnt <= '0;
      gap_cnt  <= '0;
      rom_addr <= '0;
      led      <= '0;
      buzzer   <= 1'b0;
    end else begin
      state    <= state_nxt;
      song     <= song_nxt;
      note     <= note_nxt;
      dur_cnt  <= dur_cnt_nxt;
      tone_cnt <= tone_cnt_nxt;
      gap_cnt  <= gap_cnt_nxt;
      rom_addr <= addr_nxt;
      led      <= led_nxt;
      buzzer   <= buzzer_nxt;
    end
  end

  // Next-state, counter and output decode; start overrides every state.
  always_comb begin
    state_nxt    = state;
    song_nxt     = song;
    note_nxt     = note;
    dur_cnt_nxt  = dur_cnt;
    tone_cnt_nxt = tone_cnt;
    gap_cnt_nxt  = gap_cnt;
    addr_nxt     = rom_addr;
    buzzer_nxt   = buzzer;
    frozen       = ((state == S_PLAY) || (state == S_GAP)) && pause;

    if (start) begin
      song_nxt     = song_sel;
      addr_nxt     = {song_sel, {OFF_W{1'b0}}};
      state_nxt    = S_FETCH;
      note_nxt     = '0;
      dur_cnt_nxt  = '0;
      tone_cnt_nxt = '0;
      gap_cnt_nxt  = '0;
      buzzer_nxt   = 1'b0;
    end else begin
      case (state)
        S_FETCH: state_nxt = S_LATCH;
        S_LATCH: begin
          note_nxt = code_in;
          if (code_in == END_CODE) begin
            if (loop) begin
              addr_nxt  = {song, {OFF_W{1'b0}}};
              state_nxt = S_FETCH;
            end else begin
              state_nxt = S_DONE;
            end
          end else begin
            state_nxt    = S_PLAY;
            dur_cnt_nxt  = DUR_W'((int'(dur_in) + 1) * BEAT_CYC);
            tone_cnt_nxt = hp_of(code_in);
            buzzer_nxt   = 1'b0;
          end
        end
        S_PLAY: begin
          if (frozen) begin
            // Tone restarts low with a full half period once pause drops.
            buzzer_nxt   = 1'b0;
            tone_cnt_nxt = hp_of(note);
          end else if (dur_cnt <= DUR_W'(1)) begin
            state_nxt   = S_GAP;
            dur_cnt_nxt = '0;
            gap_cnt_nxt = GAP_W'(GAP_CYC);
            buzzer_nxt  = 1'b0;
          end else begin
            dur_cnt_nxt = dur_cnt - DUR_W'(1);
            if (tone_cnt <= HP_W'(1)) begin
              tone_cnt_nxt = hp_of(note);
              if (is_tone(note)) buzzer_nxt = ~buzzer;
            end else begin
              tone_cnt_nxt = tone_cnt - HP_W'(1);
            end
          end
        end
        S_GAP: begin
          if (!frozen) begin
            if (gap_cnt <= GAP_W'(1)) begin
              state_nxt   = S_FETCH;
              gap_cnt_nxt = '0;
              // Offset wraps inside the song; the song bits never change.
              addr_nxt    = {rom_addr[ADDR_W-1 -: 2], rom_addr[OFF_W-1:0] + OFF_W'(1)};
            end else begin
              gap_cnt_nxt = gap_cnt - GAP_W'(1);
            end
          end
        end
        default: ;
      endcase
    end

    led_nxt = '0;
    for (int i = 0; i < 21; i++) begin
      led_nxt[i] = (state_nxt == S_PLAY) && (note_nxt == 5'(i + 1));
    end
    led_nxt[21] = (state_nxt == S_DONE);
    led_nxt[22] = (state_nxt == S_FETCH) || (state_nxt == S_LATCH) ||
                  (state_nxt == S_PLAY)  || (state_nxt == S_GAP);
    led_nxt[23] = frozen && !start;
  end

endmodule

// File: tb/tb_music_sequencer.sv
// Bench for music_sequencer: a reference model expands each song into the
// expected output timeline (run-length segments of {rom_addr, led, buzzer});
// a monitor collapses the DUT outputs into the same segments and compares.
module tb_music_sequencer;
  localparam int CLK_HZ   = 20_000;
  localparam int BEAT_HZ  = 100;
  localparam int GAP_CYC  = 10;
  localparam int ADDR_W   = 8;
  localparam int BEAT_CYC = CLK_HZ / BEAT_HZ;
  localparam int SONG_LEN = 1 << (ADDR_W - 2);
  localparam logic [23:0] L_ACT   = 24'h40_0000;
  localparam logic [23:0] L_DONE  = 24'h20_0000;
  localparam logic [23:0] L_PAUSE = 24'h80_0000;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        song_sel = 2'd0;
  logic              pause = 1'b0;
  logic              loop = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data = 8'd0;
  logic [23:0]       led;
  logic              buzzer;

  always #5 clk = ~clk;

  logic [7:0] rom [0:255];
  always @(posedge clk) rom_data <= rom[rom_addr];

  music_sequencer #(
    .CLK_HZ(CLK_HZ), .BEAT_HZ(BEAT_HZ), .GAP_CYC(GAP_CYC), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .song_sel(song_sel), .pause(pause),
    .loop(loop), .rom_addr(rom_addr), .rom_data(rom_data), .led(led), .buzzer(buzzer)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [23:0] led;
    logic        buz;
    int          len;
  } seg_t;

  seg_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int freq [0:20] = '{262, 294, 330, 349, 392, 440, 494, 523, 587, 659, 698,
                      784, 880, 988, 1047, 1175, 1319, 1397, 1568, 1760, 1976};

  // ---------------- reference model ----------------
  seg_t m_cur;
  bit   m_open = 0;
  int   m_cnt = 0;
  int   m_cap = 0;

  task automatic emit(input logic [7:0] a, input logic [23:0] l, input logic b);
    if (m_cnt >= m_cap) return;
    m_cnt++;
    if (m_open && m_cur.addr == a && m_cur.led == l && m_cur.buz == b) begin
      m_cur.len++;
    end else begin
      if (m_open) exp_q.push_back(m_cur);
      m_cur = '{a, l, b, 1};
      m_open = 1;
    end
  endtask

  task automatic model_close();
    if (m_open) exp_q.push_back(m_cur);
    m_open = 0;
    m_cnt  = 0;
  endtask

  function automatic logic wave(input int c, input int hp, input bit tone);
    return tone && ((((c - 1) / hp) % 2) == 1);
  endfunction

  // Expected timeline of one song, cycle 1 being the cycle after start is taken.
  // pz_len > 0 pauses the first note after pz_k unpaused play cycles.
  task automatic gen_stream(input int song, input bit lp, input int cap,
                            input int pz_k, input int pz_len);
    int a, base, code, dur, n, hp;
    bit tone, pz_done;
    logic [7:0]  ad;
    logic [23:0] nled;
    a = 0;
    base = song * SONG_LEN;
    pz_done = (pz_len == 0);
    m_cap = cap;
    while (m_cnt < m_cap) begin
      ad   = 8'(base + a);
      code = int'(rom[base + a][7:3]);
      dur  = int'(rom[base + a][2:0]);
      emit(ad, L_ACT, 1'b0);
      emit(ad, L_ACT, 1'b0);
      if (code == 31) begin
        if (lp) begin
          a = 0;
          continue;
        end
        while (m_cnt < m_cap) emit(ad, L_DONE, 1'b0);
        break;
      end
      n    = (dur + 1) * BEAT_CYC;
      tone = (code >= 1) && (code <= 21);
      hp   = tone ? CLK_HZ / (2 * freq[code - 1]) : 1;
      nled = L_ACT | (tone ? (24'(1) << (code - 1)) : 24'(0));
      if (!pz_done) begin
        for (int c = 1; c <= pz_k + 1; c++) emit(ad, nled, wave(c, hp, tone));
        for (int c = 0; c < pz_len; c++) emit(ad, nled | L_PAUSE, 1'b0);
        for (int c = 2; c <= n - pz_k; c++) emit(ad, nled, wave(c, hp, tone));
        pz_done = 1;
      end else begin
        for (int c = 1; c <= n; c++) emit(ad, nled, wave(c, hp, tone));
      end
      for (int c = 0; c < GAP_CYC; c++) emit(ad, L_ACT, 1'b0);
      a = (a + 1) % SONG_LEN;
    end
  endtask

  // ---------------- monitor ----------------
  seg_t run;
  bit   run_open = 0;
  bit   mon_en = 0;

  task automatic check_run(input seg_t got);
    seg_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL seg_underflow: got addr=%0d led=%h buz=%0b len=%0d, required no further segment",
               got.addr, got.led, got.buz, got.len);
    end else begin
      e = exp_q.pop_front();
      if (got.addr !== e.addr || got.led !== e.led || got.buz !== e.buz || got.len != e.len) begin
        n_bad++;
        $display("FAIL seg: got addr=%0d led=%h buz=%0b len=%0d, required addr=%0d led=%h buz=%0b len=%0d",
                 got.addr, got.led, got.buz, got.len, e.addr, e.led, e.buz, e.len);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (run_open && run.addr === rom_addr && run.led === led && run.buz === buzzer) begin
        run.len++;
      end else begin
        if (run_open) check_run(run);
        run = '{rom_addr, led, buzzer, 1};
        run_open = 1;
      end
    end else if (run_open) begin
      check_run(run);
      run_open = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    rst = 1'b0; start = 1'b0; pause = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Start song, then run T observed cycles; optional restart at cycle R and pause window.
  task automatic run_scen(input int song, input bit lp, input int t, input int r,
                          input int song_b, input bit pz_at_r, input int pz_k, input int pz_len);
    loop = lp; start = 1'b1; song_sel = 2'(song);
    @(posedge clk); #1;
    start = 1'b0; mon_en = 1;
    for (int c = 1; c <= t; c++) begin
      start    = (c == r);
      song_sel = (c == r) ? 2'(song_b) : 2'($urandom);
      pause    = (pz_len > 0 && c >= pz_k + 3 && c <= pz_k + pz_len + 2) || (pz_at_r && c == r);
      @(posedge clk); #1;
    end
    start = 1'b0; pause = 1'b0; mon_en = 0;
  endtask

  task automatic finish_scen(input string name);
    @(posedge clk); #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_leftover: got %0d unmatched expected segments, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic fill_song(input int song, input bit markers, input int max_dur);
    int code;
    for (int off = 0; off < SONG_LEN; off++) begin
      code = (markers && $urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 30));
      rom[song * SONG_LEN + off] = 8'((code << 3) | int'($urandom_range(0, max_dur)));
    end
  endtask

  initial begin
    int r, s, sb, t;
    bit lp, rs;
    int idle_bad;

    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);

    @(posedge clk); #1;
    check_val("reset_addr", 32'(rom_addr), 32'd0);
    check_val("reset_led", 32'(led), 32'd0);
    check_val("reset_buzzer", 32'(buzzer), 32'd0);

    // A4 for two beats then end marker, no loop
    rom[64] = 8'((6 << 3) | 1);
    rom[65] = 8'((31 << 3) | 0);
    do_reset();
    t = 2 + 2 * BEAT_CYC + GAP_CYC + 2 + 20;
    gen_stream(1, 0, t, 0, 0); model_close();
    run_scen(1, 0, t, -1, 0, 0, 0, 0);
    finish_scen("single_note");

    // same song looping
    do_reset();
    gen_stream(1, 1, 1500, 0, 0); model_close();
    run_scen(1, 1, 1500, -1, 0, 0, 0, 0);
    finish_scen("loop");

    // pause in the middle of the note
    do_reset();
    t = 2 + 2 * BEAT_CYC + 60 + GAP_CYC + 2 + 20;
    gen_stream(1, 0, t, 100, 60); model_close();
    run_scen(1, 0, t, -1, 0, 0, 100, 60);
    finish_scen("pause");

    // song 0 without end marker wraps to its own first word
    fill_song(0, 0, 0);
    do_reset();
    t = SONG_LEN * (2 + BEAT_CYC + GAP_CYC) + 300;
    gen_stream(0, 0, t, 0, 0); model_close();
    run_scen(0, 0, t, -1, 0, 0, 0, 0);
    finish_scen("wrap");

    // restart to song 2 in the middle of song 0's first note, pause high with start
    fill_song(2, 1, 1);
    lp = 1'($urandom);
    r = $urandom_range(3, 2 + BEAT_CYC);
    do_reset();
    gen_stream(0, lp, r, 0, 0);
    gen_stream(2, lp, r + 2000, 0, 0); model_close();
    run_scen(0, lp, r + 2000, r, 2, 1, 0, 0);
    finish_scen("restart");

    // asynchronous reset while playing
    do_reset();
    gen_stream(0, 0, 100, 0, 0); model_close();
    run_scen(0, 0, 100, -1, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    check_val("async_rst_addr", 32'(rom_addr), 32'd0);
    check_val("async_rst_led", 32'(led), 32'd0);
    check_val("async_rst_buzzer", 32'(buzzer), 32'd0);
    finish_scen("pre_rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle_bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rom_addr !== '0 || led !== '0 || buzzer !== 1'b0) idle_bad++;
    end
    check_val("idle_after_rst", 32'(idle_bad), 32'd0);
    @(posedge clk); #1;

    // random songs, random loop, optional restart
    for (int k = 0; k < 4; k++) begin
      s  = $urandom_range(0, 3);
      sb = $urandom_range(0, 3);
      lp = 1'($urandom);
      rs = 1'($urandom);
      fill_song(s, 1, 2);
      if (sb != s) fill_song(sb, 1, 2);
      r = rs ? int'($urandom_range(3, 1500)) : -1;
      t = 3000;
      do_reset();
      if (rs) begin
        gen_stream(s, lp, r, 0, 0);
        gen_stream(sb, lp, t, 0, 0);
      end else begin
        gen_stream(s, lp, t, 0, 0);
      end
      model_close();
      run_scen(s, lp, t, r, sb, 0, 0, 0);
      finish_scen("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
